imem_loader: RTL and testbench

Parametrised instruction-memory and run-control block for the RV32 datapath bench and FPGA bring-up. It accepts a program as a little-endian byte stream over a valid/ready port and stores it in a byte-addressed memory. During loading it holds the core in reset. It then releases the core, serves 32-bit instruction fetches, counts cycles, and stops the run on ECALL or on a cycle-budget timeout.

---
 rtl/imem_pkg.sv | 17 +
 rtl/imem_loader_byte_mem.sv | 32 +++
 rtl/imem_loader.sv | 121 ++++++++++++
 tb/tb_imem_loader.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory loader.
// Imported by the loader top and its testbench.
package imem_pkg;

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } ld_state_t;

    localparam logic [31:0] INSTR_NOP   = 32'h0000_0013;
    localparam logic [31:0] INSTR_ECALL = 32'h0000_0073;

    localparam int ERR_MISALIGN = 0;
    localparam int ERR_TIMEOUT  = 1;

endpackage

// File: rtl/imem_loader_byte_mem.sv
// Byte-addressed program store: one write port and a
// little-endian 4-byte combinational read port with modulo wrap.
module byte_mem #(
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [7:0]        wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [31:0]       rdata
);

    localparam int DEPTH = 2 ** ADDR_W;

    // Contents are deliberately not reset; the loader masks them.
    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_comb begin
        rdata = '0;
        for (int i = 0; i < 4; i++) begin
            rdata[8*i +: 8] = mem[raddr + ADDR_W'(i)];
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Program loader and run control: streams a program into memory,
// releases the core, serves fetches and halts on ECALL or timeout.
module imem_loader
    import imem_pkg::*;
#(
    parameter int ADDR_W     = 12,
    parameter int MAX_CYCLES = 100000,
    parameter int CNT_W      = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ld_valid,
    input  logic [7:0]        ld_data,
    input  logic              ld_last,
    output logic              ld_ready,
    input  logic [ADDR_W-1:0] fetch_pc,
    output logic [31:0]       fetch_instr,
    output logic              core_rst_n,
    output logic              running,
    output logic              done,
    output logic [ADDR_W:0]   load_count,
    output logic [CNT_W-1:0]  cycle_count,
    output logic [1:0]        err
);

    ld_state_t state, state_nxt;

    logic [ADDR_W-1:0] wptr;
    logic [31:0]       raw_word;
    logic              accept;
    logic              last_byte;
    logic              aligned;
    logic              loaded;
    logic              in_run;
    logic              is_ecall;
    logic              timeout;

    assign in_run    = (state == RUN);
    assign accept    = (state == LOAD) && ld_valid;
    assign last_byte = accept && (ld_last || (&wptr));
    assign aligned   = (fetch_pc[1:0] == 2'b00);

    // An aligned word never wraps, so one bound check covers all 4 bytes.
    assign loaded = (({1'b0, fetch_pc} + (ADDR_W+1)'(4)) <= load_count);

    byte_mem #(
        .ADDR_W(ADDR_W)
    ) u_mem (
        .clk  (clk),
        .we   (accept),
        .waddr(wptr),
        .wdata(ld_data),
        .raddr(fetch_pc),
        .rdata(raw_word)
    );

    assign fetch_instr = (in_run && aligned && loaded) ? raw_word : INSTR_NOP;
    assign is_ecall    = in_run && (fetch_instr == INSTR_ECALL);
    assign timeout     = in_run && (cycle_count == CNT_W'(MAX_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= LOAD;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        ld_ready   = 1'b0;
        core_rst_n = 1'b0;
        running    = 1'b0;
        done       = 1'b0;
        unique case (state)
            LOAD: begin
                ld_ready = 1'b1;
                if (last_byte) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                core_rst_n = 1'b1;
                running    = 1'b1;
                if (is_ecall || timeout) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done = 1'b1;
            end
            default: begin
                state_nxt = LOAD;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr        <= '0;
            load_count  <= '0;
            cycle_count <= '0;
            err         <= '0;
        end else begin
            if (accept) begin
                wptr       <= wptr + ADDR_W'(1);
                load_count <= load_count + (ADDR_W+1)'(1);
            end
            if (in_run) begin
                cycle_count <= cycle_count + CNT_W'(1);
                if (!aligned) begin
                    err[ERR_MISALIGN] <= 1'b1;
                end
                if (timeout) begin
                    err[ERR_TIMEOUT] <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: stimulus queues expectations,
// a negedge monitor pops and compares them against the outputs.
module tb_imem_loader;
    import imem_pkg::*;

    localparam int ADDR_W = 4;
    localparam int MAXC   = 10;
    localparam int CNT_W  = 32;

    localparam int KF = 0;  // fetch_instr
    localparam int KC = 1;  // core_rst_n
    localparam int KU = 2;  // running
    localparam int KD = 3;  // done
    localparam int KL = 4;  // load_count
    localparam int KY = 5;  // cycle_count
    localparam int KE = 6;  // err
    localparam int KR = 7;  // ld_ready

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              ld_valid = 1'b0;
    logic [7:0]        ld_data = '0;
    logic              ld_last = 1'b0;
    logic              ld_ready;
    logic [ADDR_W-1:0] fetch_pc = '0;
    logic [31:0]       fetch_instr;
    logic              core_rst_n;
    logic              running;
    logic              done;
    logic [ADDR_W:0]   load_count;
    logic [CNT_W-1:0]  cycle_count;
    logic [1:0]        err;

    imem_loader #(
        .ADDR_W    (ADDR_W),
        .MAX_CYCLES(MAXC),
        .CNT_W     (CNT_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ld_valid   (ld_valid),
        .ld_data    (ld_data),
        .ld_last    (ld_last),
        .ld_ready   (ld_ready),
        .fetch_pc   (fetch_pc),
        .fetch_instr(fetch_instr),
        .core_rst_n (core_rst_n),
        .running    (running),
        .done       (done),
        .load_count (load_count),
        .cycle_count(cycle_count),
        .err        (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        int          kind;
        logic [31:0] val;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;

    logic [7:0] prog [16];

    function automatic logic [31:0] actual(input int k);
        case (k)
            KF:      return fetch_instr;
            KC:      return {31'd0, core_rst_n};
            KU:      return {31'd0, running};
            KD:      return {31'd0, done};
            KL:      return {27'd0, load_count};
            KY:      return cycle_count;
            KE:      return {30'd0, err};
            default: return {31'd0, ld_ready};
        endcase
    endfunction

    always @(negedge clk) begin
        while (q.size() > 0) begin
            exp_t e;
            logic [31:0] a;
            e = q.pop_front();
            a = actual(e.kind);
            tests++;
            if (a !== e.val) begin
                fails++;
                $display("FAIL %s: got %0h expected %0h", e.name, a, e.val);
            end
        end
    end

    task automatic chk(input string n, input int k, input logic [31:0] v);
        exp_t e;
        e.name = n;
        e.kind = k;
        e.val  = v;
        q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        fetch_pc = '0;
        step();
        step();
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    task automatic load(input int n, input bit last, input bit gaps);
        for (int i = 0; i < n; i++) begin
            if (gaps && (i % 3 == 1)) begin
                ld_valid = 1'b0;
                chk("gap_ready", KR, 1);
                chk("gap_core_rst", KC, 0);
                chk("gap_running", KU, 0);
                step();
            end
            ld_valid = 1'b1;
            ld_data  = prog[i];
            ld_last  = last && (i == n - 1);
            chk("load_ready", KR, 1);
            chk("load_count_pre", KL, i);
            step();
        end
        ld_valid = 1'b0;
        ld_last  = 1'b0;
    endtask

    task automatic set_prog_a();
        prog[0] = 8'd19;  prog[1] = 8'd6;   prog[2] = 8'd80;  prog[3] = 8'd0;
        prog[4] = 8'd147; prog[5] = 8'd102; prog[6] = 8'd176; prog[7] = 8'd0;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) prog[i] = 8'h00;

        // Reset state
        do_reset();
        chk("rst_ready", KR, 1);
        chk("rst_core", KC, 0);
        chk("rst_running", KU, 0);
        chk("rst_done", KD, 0);
        chk("rst_load_count", KL, 0);
        chk("rst_cycles", KY, 0);
        chk("rst_err", KE, 0);
        step();

        // First-word load, misaligned fetch, writes ignored in RUN
        set_prog_a();
        load(8, 1'b1, 1'b0);
        fetch_pc = 4'd0;
        chk("w0_core_rst", KC, 1);
        chk("w0_running", KU, 1);
        chk("w0_ready", KR, 0);
        chk("w0_instr", KF, 32'h0050_0613);
        chk("w0_load_count", KL, 8);
        chk("w0_cycles", KY, 0);
        step();
        fetch_pc = 4'd4;
        chk("w1_instr", KF, 32'h00B0_6693);
        chk("w1_cycles", KY, 1);
        step();
        fetch_pc = 4'd2;
        chk("mis_instr", KF, INSTR_NOP);
        chk("mis_err_pre", KE, 0);
        step();
        fetch_pc = 4'd0;
        chk("mis_err", KE, 2'b01);
        chk("mis_running", KU, 1);
        chk("mis_cycles", KY, 3);
        ld_valid = 1'b1;
        ld_data  = 8'h73;
        step();
        ld_valid = 1'b0;
        fetch_pc = 4'd8;
        chk("run_no_write", KL, 8);
        chk("run_unloaded", KF, INSTR_NOP);
        chk("run_ready", KR, 0);
        step();

        // Reset mid-run drops core reset at once
        rst_n = 1'b0;
        chk("mid_core_rst", KC, 0);
        chk("mid_running", KU, 0);
        chk("mid_cycles", KY, 0);
        chk("mid_load_count", KL, 0);
        chk("mid_err", KE, 0);
        step();
        do_reset();
        chk("post_ready", KR, 1);
        chk("post_load_count", KL, 0);
        chk("post_err", KE, 0);
        chk("post_cycles", KY, 0);

        // Unloaded-word NOP
        load(6, 1'b1, 1'b0);
        fetch_pc = 4'd0;
        chk("p6_instr0", KF, 32'h0050_0613);
        chk("p6_load_count", KL, 6);
        step();
        fetch_pc = 4'd4;
        chk("p6_instr1_nop", KF, INSTR_NOP);
        step();

        // ECALL halt
        do_reset();
        prog[4] = 8'h73; prog[5] = 8'h00; prog[6] = 8'h00; prog[7] = 8'h00;
        load(8, 1'b1, 1'b0);
        fetch_pc = 4'd0;
        chk("ec_instr0", KF, 32'h0050_0613);
        chk("ec_cycles0", KY, 0);
        step();
        fetch_pc = 4'd4;
        chk("ec_instr1", KF, INSTR_ECALL);
        chk("ec_cycles1", KY, 1);
        step();
        chk("ec_done", KD, 1);
        chk("ec_running", KU, 0);
        chk("ec_core_rst", KC, 0);
        chk("ec_cycles", KY, 2);
        chk("ec_err", KE, 0);
        chk("ec_fetch_nop", KF, INSTR_NOP);
        chk("ec_ready", KR, 0);
        ld_valid = 1'b1;
        step();
        ld_valid = 1'b0;
        chk("ec_freeze_cycles", KY, 2);
        chk("ec_freeze_load", KL, 8);
        chk("ec_still_done", KD, 1);
        step();

        // Timeout on a NOP loop
        do_reset();
        prog[0] = 8'h13; prog[1] = 8'h00; prog[2] = 8'h00; prog[3] = 8'h00;
        load(4, 1'b1, 1'b0);
        fetch_pc = 4'd0;
        for (int i = 0; i < MAXC; i++) begin
            chk("to_running", KU, 1);
            chk("to_cycles", KY, i);
            step();
        end
        chk("to_done", KD, 1);
        chk("to_err", KE, 2'b10);
        chk("to_cycles_final", KY, MAXC);
        chk("to_running_off", KU, 0);
        step();

        // Full-memory load with gaps, no ld_last
        do_reset();
        for (int i = 0; i < 16; i++) prog[i] = 8'h00;
        prog[0]  = 8'h13;
        prog[12] = 8'h93; prog[13] = 8'h66; prog[14] = 8'hB0; prog[15] = 8'h00;
        load(16, 1'b0, 1'b1);
        fetch_pc = 4'd12;
        chk("full_running", KU, 1);
        chk("full_load_count", KL, 16);
        chk("full_instr", KF, 32'h00B0_6693);
        chk("full_ready", KR, 0);
        step();

        @(negedge clk);
        #1;
        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL drain: got %0d expected 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
